// File: rtl/huffdec_pkg.sv
// Shared constants, types and helpers for the 6-symbol Huffman decoder.
package huffdec_pkg;

  localparam int SYM_N  = 6;
  localparam int CODE_W = 5;

  typedef logic [2:0] sym_t;

  typedef enum logic {
    EMPTY,
    RUN
  } state_t;

  // Length mask (1<<len)-1 in the same form the encoder publishes.
  function automatic logic [CODE_W-1:0] len_mask(input logic [2:0] len);
    logic [CODE_W:0] w_full;
    w_full   = (CODE_W+1)'(1) << len;
    len_mask = CODE_W'(w_full - (CODE_W+1)'(1));
  endfunction

endpackage

// File: rtl/huffdec_match.sv
// Combinational compare of one code-table entry against the candidate code.
module huffdec_match
  import huffdec_pkg::*;
(
  input  logic [CODE_W-1:0] i_hc,
  input  logic [CODE_W-1:0] i_mask,
  input  logic [CODE_W-1:0] i_sr,
  input  logic [2:0]        i_len,
  output logic              o_hit
);

  // An unused symbol has a zero mask and must never match.
  assign o_hit = (i_mask != '0) &&
                 (i_mask == len_mask(i_len)) &&
                 ((i_sr & i_mask) == i_hc);

endmodule

// File: rtl/huffman_decoder.sv
// Serial Huffman decoder for the 6-symbol encoder's published code table.
// Optional per-symbol counters DCNT1..DCNT6 are enabled by defining HUFFDEC_CNT_EN.
module huffman_decoder
  import huffdec_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tbl_load,
  input  logic [7:0] HC1,
  input  logic [7:0] HC2,
  input  logic [7:0] HC3,
  input  logic [7:0] HC4,
  input  logic [7:0] HC5,
  input  logic [7:0] HC6,
  input  logic [7:0] M1,
  input  logic [7:0] M2,
  input  logic [7:0] M3,
  input  logic [7:0] M4,
  input  logic [7:0] M5,
  input  logic [7:0] M6,
  input  logic       bit_valid,
  input  logic       bit_data,
  output logic       tbl_ok,
  output logic       sym_valid,
  output logic [2:0] sym_data,
  output logic       err,
  output logic [7:0] sym_cnt
`ifdef HUFFDEC_CNT_EN
  ,
  output logic [7:0] DCNT1,
  output logic [7:0] DCNT2,
  output logic [7:0] DCNT3,
  output logic [7:0] DCNT4,
  output logic [7:0] DCNT5,
  output logic [7:0] DCNT6
`endif
);

  logic [CODE_W-1:0] w_hc_in [SYM_N];
  logic [CODE_W-1:0] w_m_in  [SYM_N];

  assign w_hc_in[0] = HC1[CODE_W-1:0];
  assign w_hc_in[1] = HC2[CODE_W-1:0];
  assign w_hc_in[2] = HC3[CODE_W-1:0];
  assign w_hc_in[3] = HC4[CODE_W-1:0];
  assign w_hc_in[4] = HC5[CODE_W-1:0];
  assign w_hc_in[5] = HC6[CODE_W-1:0];
  assign w_m_in[0]  = M1[CODE_W-1:0];
  assign w_m_in[1]  = M2[CODE_W-1:0];
  assign w_m_in[2]  = M3[CODE_W-1:0];
  assign w_m_in[3]  = M4[CODE_W-1:0];
  assign w_m_in[4]  = M5[CODE_W-1:0];
  assign w_m_in[5]  = M6[CODE_W-1:0];

  state_t            r_state;
  logic [CODE_W-1:0] r_hc [SYM_N];
  logic [CODE_W-1:0] r_m  [SYM_N];
  logic [CODE_W-1:0] r_sr;
  logic [2:0]        r_len;
  logic              r_tbl_ok;
  logic              r_sym_valid;
  sym_t              r_sym_data;
  logic              r_err;
  logic [7:0]        r_sym_cnt;

  logic [CODE_W-1:0] w_sr_n;
  logic [2:0]        w_len_n;
  logic [SYM_N-1:0]  w_hit;
  logic              w_any;
  sym_t              w_idx;

  assign w_sr_n  = {r_sr[CODE_W-2:0], bit_data};
  assign w_len_n = r_len + 3'd1;

  for (genvar g = 0; g < SYM_N; g++) begin : g_match
    huffdec_match u_match (
      .i_hc   (r_hc[g]),
      .i_mask (r_m[g]),
      .i_sr   (w_sr_n),
      .i_len  (w_len_n),
      .o_hit  (w_hit[g])
    );
  end

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    for (int i = SYM_N - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_any = 1'b1;
        w_idx = sym_t'(i);
      end
    end
  end

`ifdef HUFFDEC_CNT_EN
  logic [7:0] r_dcnt [SYM_N];

  assign DCNT1 = r_dcnt[0];
  assign DCNT2 = r_dcnt[1];
  assign DCNT3 = r_dcnt[2];
  assign DCNT4 = r_dcnt[3];
  assign DCNT5 = r_dcnt[4];
  assign DCNT6 = r_dcnt[5];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= EMPTY;
      r_sr        <= '0;
      r_len       <= '0;
      r_tbl_ok    <= 1'b0;
      r_sym_valid <= 1'b0;
      r_sym_data  <= '0;
      r_err       <= 1'b0;
      r_sym_cnt   <= '0;
      for (int i = 0; i < SYM_N; i++) begin
        r_hc[i] <= '0;
        r_m[i]  <= '0;
`ifdef HUFFDEC_CNT_EN
        r_dcnt[i] <= '0;
`endif
      end
    end else begin
      r_sym_valid <= 1'b0;
      r_err       <= 1'b0;
      // A load always wins over a bit arriving on the same edge.
      if (tbl_load) begin
        r_state   <= RUN;
        r_sr      <= '0;
        r_len     <= '0;
        r_tbl_ok  <= 1'b1;
        r_sym_cnt <= '0;
        for (int i = 0; i < SYM_N; i++) begin
          r_hc[i] <= w_hc_in[i];
          r_m[i]  <= w_m_in[i];
`ifdef HUFFDEC_CNT_EN
          r_dcnt[i] <= '0;
`endif
        end
      end else if (r_state == RUN && bit_valid) begin
        if (w_any) begin
          r_sym_valid <= 1'b1;
          r_sym_data  <= w_idx + sym_t'(1);
          r_sr        <= '0;
          r_len       <= '0;
          if (r_sym_cnt != 8'hFF) r_sym_cnt <= r_sym_cnt + 8'd1;
`ifdef HUFFDEC_CNT_EN
          if (r_dcnt[w_idx] != 8'hFF) r_dcnt[w_idx] <= r_dcnt[w_idx] + 8'd1;
`endif
        end else if (w_len_n == 3'(CODE_W)) begin
          r_err <= 1'b1;
          r_sr  <= '0;
          r_len <= '0;
        end else begin
          r_sr  <= w_sr_n;
          r_len <= w_len_n;
        end
      end
    end
  end

  assign tbl_ok    = r_tbl_ok;
  assign sym_valid = r_sym_valid;
  assign sym_data  = r_sym_data;
  assign err       = r_err;
  assign sym_cnt   = r_sym_cnt;

endmodule

// File: tb/tb_huffman_decoder.sv
// Scoreboard bench for huffman_decoder: a bit-string reference model predicts
// each symbol/error event; a monitor pops and compares when the DUT pulses.
module tb_huffman_decoder;

  logic       clk;
  logic       reset_n;
  logic       tbl_load;
  logic [7:0] hcIn [6];
  logic [7:0] mIn  [6];
  logic       bit_valid;
  logic       bit_data;
  logic       tbl_ok;
  logic       sym_valid;
  logic [2:0] sym_data;
  logic       err;
  logic [7:0] sym_cnt;
`ifdef HUFFDEC_CNT_EN
  logic [7:0] dcnt [6];
`endif

  huffman_decoder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tbl_load  (tbl_load),
    .HC1       (hcIn[0]),
    .HC2       (hcIn[1]),
    .HC3       (hcIn[2]),
    .HC4       (hcIn[3]),
    .HC5       (hcIn[4]),
    .HC6       (hcIn[5]),
    .M1        (mIn[0]),
    .M2        (mIn[1]),
    .M3        (mIn[2]),
    .M4        (mIn[3]),
    .M5        (mIn[4]),
    .M6        (mIn[5]),
    .bit_valid (bit_valid),
    .bit_data  (bit_data),
    .tbl_ok    (tbl_ok),
    .sym_valid (sym_valid),
    .sym_data  (sym_data),
    .err       (err),
    .sym_cnt   (sym_cnt)
`ifdef HUFFDEC_CNT_EN
    ,
    .DCNT1     (dcnt[0]),
    .DCNT2     (dcnt[1]),
    .DCNT3     (dcnt[2]),
    .DCNT4     (dcnt[3]),
    .DCNT5     (dcnt[4]),
    .DCNT6     (dcnt[5])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc++;

  int errorCount = 0;
  int checkCount = 0;

  typedef struct {
    bit     isErr;
    int     sym;
    int     cnt;
    longint cyc;
  } exp_t;
  exp_t expQ[$];

  // Reference model: the code table as (value, length) pairs plus the bits
  // received so far, held as an integer and a bit count.
  int refHc  [6];
  int refLen [6];
  int refDcnt[6];
  bit refLoaded;
  int accVal;
  int accLen;
  int refCnt;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checkCount++;
    if (actual != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    refLoaded = 1'b0;
    accVal = 0;
    accLen = 0;
    refCnt = 0;
    for (int i = 0; i < 6; i++) begin
      refHc[i] = 0;
      refLen[i] = 0;
      refDcnt[i] = 0;
    end
  endtask

  task automatic modelLoad();
    refLoaded = 1'b1;
    accVal = 0;
    accLen = 0;
    refCnt = 0;
    for (int i = 0; i < 6; i++) begin
      int m;
      m = mIn[i] & 31;
      refHc[i] = hcIn[i] & 31;
      refLen[i] = 0;
      refDcnt[i] = 0;
      for (int l = 1; l <= 5; l++)
        if (m == (1 << l) - 1) refLen[i] = l;
    end
  endtask

  task automatic modelBit(input int b);
    int hit;
    if (!refLoaded) return;
    accVal = accVal * 2 + b;
    accLen++;
    hit = -1;
    for (int i = 0; i < 6; i++) begin
      if (hit < 0 && refLen[i] == accLen && refHc[i] == accVal) hit = i;
    end
    if (hit >= 0) begin
      if (refCnt < 255) refCnt++;
      if (refDcnt[hit] < 255) refDcnt[hit]++;
      expQ.push_back('{isErr: 1'b0, sym: hit + 1, cnt: refCnt, cyc: cyc + 1});
      accVal = 0;
      accLen = 0;
    end else if (accLen == 5) begin
      expQ.push_back('{isErr: 1'b1, sym: 0, cnt: refCnt, cyc: cyc + 1});
      accVal = 0;
      accLen = 0;
    end
  endtask

  // Drive one cycle's inputs on the falling edge and let the model see them.
  task automatic applyStimulus(input bit doLoad, input bit doBit, input bit b);
    @(negedge clk);
    tbl_load  = doLoad;
    bit_valid = doBit;
    bit_data  = doBit ? b : 1'b0;
    if (doLoad) modelLoad();
    else if (doBit) modelBit(int'(b));
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic sendBits(input logic [15:0] bits, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      applyStimulus(1'b0, 1'b1, bits[i]);
      idle(gap);
    end
  endtask

  task automatic setTableA();
    int hcA[6] = '{0, 2, 6, 14, 30, 31};
    int mA[6]  = '{1, 3, 7, 15, 31, 31};
    for (int i = 0; i < 6; i++) begin
      hcIn[i] = 8'(hcA[i]);
      mIn[i]  = 8'(mA[i]);
    end
  endtask

  // Table A with its codes shuffled across symbols, optionally complemented,
  // and occasionally with one symbol disabled so some streams hit errors.
  task automatic setRandomTable();
    int perm[6];
    bit inv;
    setTableA();
    for (int i = 0; i < 6; i++) perm[i] = i;
    for (int i = 5; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(0, i));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    inv = 1'($urandom_range(0, 1));
    begin
      logic [7:0] h[6], m[6];
      for (int i = 0; i < 6; i++) begin
        h[i] = hcIn[perm[i]];
        m[i] = mIn[perm[i]];
      end
      for (int i = 0; i < 6; i++) begin
        mIn[i]  = m[i];
        hcIn[i] = inv ? ((~h[i]) & m[i]) : h[i];
      end
    end
    if ($urandom_range(0, 3) == 0) mIn[$urandom_range(0, 5)] = 8'd0;
  endtask

  task automatic doReset();
    @(negedge clk);
    #2;
    reset_n   = 1'b0;
    tbl_load  = 1'b0;
    bit_valid = 1'b0;
    bit_data  = 1'b0;
    modelReset();
    expQ.delete();
    #1;
    checkOutput("rstTblOk",    tbl_ok,    0);
    checkOutput("rstSymValid", sym_valid, 0);
    checkOutput("rstSymData",  sym_data,  0);
    checkOutput("rstErr",      err,       0);
    checkOutput("rstSymCnt",   sym_cnt,   0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Monitor: flag events that were due but never came, then match any pulse.
  always @(negedge clk) begin
    if (reset_n) begin
      while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput(e.isErr ? "missedErr" : "missedSym", 0, 1);
      end
      if (sym_valid || err) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedPulse", {sym_valid, err}, 0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("evtKind", {sym_valid, err}, e.isErr ? 2'b01 : 2'b10);
          checkOutput("evtCycle", cyc, e.cyc);
          checkOutput("evtSymCnt", sym_cnt, e.cnt);
          if (!e.isErr) checkOutput("evtSymData", sym_data, e.sym);
        end
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    tbl_load  = 1'b0;
    bit_valid = 1'b0;
    bit_data  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      hcIn[i] = 8'd0;
      mIn[i]  = 8'd0;
    end
    modelReset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    doReset();

    // Bits before any load are ignored.
    sendBits(16'b0101, 4, 0);
    idle(2);
    checkOutput("gatedTblOk", tbl_ok, 0);
    checkOutput("gatedSymCnt", sym_cnt, 0);

    // Basic decode: 0 | 10 | 11111 -> 1, 2, 6.
    setTableA();
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(1);
    checkOutput("loadTblOk", tbl_ok, 1);
    sendBits(16'b0_10_11111, 8, 0);
    idle(2);
    checkOutput("basicSymCnt", sym_cnt, 3);
    checkOutput("basicHeldData", sym_data, 6);

    // Gaps between bits.
    sendBits(16'b110, 3, 3);
    idle(2);
    checkOutput("gapHeldData", sym_data, 3);

    // No-match error with symbol 6 disabled, then recovery.
    setTableA();
    mIn[5] = 8'd0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    sendBits(16'b11111, 5, 0);
    idle(2);
    checkOutput("errSymCnt", sym_cnt, 0);
    sendBits(16'b0, 1, 0);
    idle(2);
    checkOutput("errRecoverData", sym_data, 1);

    // Reload mid-code with a colliding bit.
    setTableA();
    applyStimulus(1'b1, 1'b0, 1'b0);
    sendBits(16'b11, 2, 0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    idle(2);
    checkOutput("reloadSymCnt", sym_cnt, 0);
    checkOutput("reloadTblOk", tbl_ok, 1);
    sendBits(16'b0, 1, 0);
    idle(2);
    checkOutput("reloadData", sym_data, 1);

    // Reset mid-code.
    sendBits(16'b11, 2, 0);
    idle(1);
    doReset();
    sendBits(16'b00, 2, 0);
    idle(2);
    checkOutput("postRstTblOk", tbl_ok, 0);

    // Saturation of the counters.
    setTableA();
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (300) applyStimulus(1'b0, 1'b1, 1'b0);
    idle(2);
    checkOutput("satSymCnt", sym_cnt, 255);
`ifdef HUFFDEC_CNT_EN
    checkOutput("satDcnt1", dcnt[0], 255);
    for (int i = 1; i < 6; i++) checkOutput($sformatf("satDcnt%0d", i + 1), dcnt[i], 0);
`endif

    // Randomized tables and streams with gaps and occasional reloads.
    for (int r = 0; r < 20; r++) begin
      setRandomTable();
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 150; c++) begin
        int p;
        p = int'($urandom_range(0, 99));
        if (p < 2) applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        else if (p < 72) applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)));
        else applyStimulus(1'b0, 1'b0, 1'b0);
      end
      idle(3);
      checkOutput("rndSymCnt", sym_cnt, refCnt);
`ifdef HUFFDEC_CNT_EN
      for (int i = 0; i < 6; i++) checkOutput($sformatf("rndDcnt%0d", i + 1), dcnt[i], refDcnt[i]);
`endif
    end

    idle(5);
    checkOutput("queueDrained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/huffman_decoder.md
# huffman_decoder

Receive-side counterpart of the 6-symbol Huffman encoder. The block captures the code table the encoder publishes: per symbol, a code value HCn and a length mask Mn, loaded on the encoder's code-valid pulse. It then decodes a serial bitstream, MSB (root decision) first, back into symbols 1..6. It sits after the encoder in the gray-level compression path and closes the loop for self-check against the encoder's histogram.

## Interface
Parameters:
- SYM_N, 6, number of symbols (fixed by table ports)
- CODE_W, 5, maximum code length in bits

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- tbl_load  in  1  one-cycle pulse; capture HC1..HC6, M1..M6
- HC1..HC6  in  8 each  code values; bits [4:0] used
- M1..M6  in  8 each  length masks, (1<<L)-1; bits [4:0] used; 0 = symbol unused
- bit_valid  in  1  serial bit strobe
- bit_data  in  1  serial code bit
- tbl_ok  out  1  table loaded, decoder running
- sym_valid  out  1  one-cycle pulse, decoded symbol
- sym_data  out  3  decoded symbol 1..6
- err  out  1  one-cycle pulse, 5 bits with no match
- sym_cnt  out  8  total symbols decoded since load, saturating at 255

## Operation
- **FSM states:**
  - EMPTY: reset state. bit_valid is ignored. tbl_load moves the FSM to RUN.
  - RUN: decoding. A further tbl_load reloads the table and stays in RUN.
- **Table capture:** on tbl_load, store hc[i] = HCi[4:0] and m[i] = Mi[4:0]. On the same edge:
  - clear the shift register sr[4:0] and length len[2:0];
  - clear sym_cnt;
  - set tbl_ok = 1.
- **Bit accept (RUN, bit_valid = 1, tbl_load = 0):**
  - sr_n = {sr[3:0], bit_data}; len_n = len + 1.
  - Entry i matches when m[i] != 0, m[i] == (1<<len_n) - 1 and (sr_n & m[i]) == hc[i].
  - Exactly one match: register sym_valid = 1 and sym_data = i + 1, increment sym_cnt (saturating), clear sr and len.
  - No match and len_n == CODE_W: assert err, clear sr and len.
  - No match and len_n < CODE_W: store sr_n and len_n.
  - More than one match can only occur with a malformed table. In that case the lowest index wins; this is not checked.
- **Simultaneous events:**
  - tbl_load together with bit_valid: the load wins and the bit is dropped.
  - A reload mid-code discards the partial code, with no err.
- One bit can be accepted every cycle. There is no backpressure.

## Timing
- **Reset values:** tbl_ok = 0, sym_valid = 0, sym_data = 0, err = 0, sym_cnt = 0, sr = 0, len = 0, table all zero, DCNTn = 0.
- **Latency:** sym_valid and err rise in the cycle after the edge that accepts the completing bit, and last exactly one cycle.
- sym_data holds its last value between pulses.
- tbl_ok rises the cycle after the tbl_load edge.
- Reset asserted mid-code immediately returns the block to EMPTY with all outputs at their reset values.

## Configuration
- **HUFFDEC_CNT_EN defined:** adds outputs DCNT1..DCNT6 (8 bits each). Each is the per-symbol decoded count, saturating at 255 and cleared on tbl_load. This lets a bench compare directly against the encoder's CNT1..CNT6.
- **HUFFDEC_CNT_EN undefined:** the ports and counters are absent. Decode behaviour is identical.

## Structure
- **Package huffdec_pkg:** SYM_N and CODE_W constants, the sym_t (3-bit) type, and the state enum {EMPTY, RUN}.
- **Sub-module huffdec_match:** combinational compare of one table entry against sr_n/len_n. It is instantiated SYM_N times and feeds a priority encoder in the top.

## Test plan
Table A: HC = 0, 2, 6, 14, 30, 31; M = 1, 3, 7, 15, 31, 31.

1. **Basic decode.** Reset, load Table A, then bits 0 | 1 0 | 1 1 1 1 1. Expect sym_data 1, 2, 6 on three sym_valid pulses, each one cycle after the last bit of its code; sym_cnt = 3.
2. **Gaps in bit_valid.** Send 1 1 0 with idle cycles between the bits. Expect a single sym_valid with sym_data = 3 and no err.
3. **No-match error.** Load Table A but with M6 = 0, then send 1 1 1 1 1. Expect err one cycle after the 5th bit, no sym_valid, and sr cleared. A following 0 then yields sym_data = 1.
4. **Reload mid-code.** Send 1 1, then tbl_load with bit_valid = 1 in the same cycle. Expect the bit dropped, sym_cnt = 0 and tbl_ok stays 1. Then 0 yields sym_data = 1.
5. **Gating and reset.** Bits before any tbl_load produce no output and tbl_ok = 0. Asserting reset_n low mid-code clears all outputs at once.
6. **Saturation (HUFFDEC_CNT_EN).** Send 300 consecutive 0 bits with Table A. Expect DCNT1 = 255, sym_cnt = 255 and DCNT2..DCNT6 = 0.
